// File: rtl/dsp_pkg.sv
// Shared DSP types: magnitude width, magnitude type and
// the windowed-statistics state encoding.
package dsp_pkg;

  localparam int MAG_W = 12;

  typedef logic [MAG_W-1:0] mag_t;

  typedef enum logic {
    IDLE,
    ACCUM
  } peak_state_e;

endpackage

// File: rtl/dsp_peak_detector_if.sv
// Sample-in / result-out bundle of the windowed peak detector.
// master drives samples, slave produces the result record.
interface dsp_peak_detector_if #(
  parameter int DATA_W = 14,
  parameter int MAG_W  = 12,
  parameter int WINDOW = 64
);

  localparam int CW = $clog2(WINDOW);

  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic [MAG_W-1:0]  i_thresh;
  logic              i_clear;
  logic [MAG_W-1:0]  o_peak;
  logic [MAG_W-1:0]  o_avg;
  logic [CW:0]       o_over;
  logic              o_valid;

  modport master (
    output i_data,
    output i_valid,
    output i_thresh,
    output i_clear,
    input  o_peak,
    input  o_avg,
    input  o_over,
    input  o_valid
  );

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_thresh,
    input  i_clear,
    output o_peak,
    output o_avg,
    output o_over,
    output o_valid
  );

endinterface

// File: rtl/dsp_window_counter.sv
// Modulo-WINDOW sample counter with a last-slot flag,
// shared by the windowed DSP blocks.
module dsp_window_counter #(
  parameter int WINDOW = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       inc,
  input  logic                       clr,
  output logic [$clog2(WINDOW)-1:0]  cnt,
  output logic                       last
);

  localparam int CW = $clog2(WINDOW);

  localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dsp_peak_detector.sv
// Windowed peak / truncated mean / over-threshold count
// over the rectified magnitude stream.
module dsp_peak_detector #(
  parameter int DATA_W = 14,
  parameter int MAG_W  = 12,
  parameter int WINDOW = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  dsp_peak_detector_if.slave bus
);

  import dsp_pkg::*;

  localparam int CW    = $clog2(WINDOW);
  localparam int SUM_W = MAG_W + CW;

  logic [MAG_W-1:0] mag;
  logic             accept;
  logic             last;
  logic [CW-1:0]    cnt_unused;
  logic             data_unused;

  peak_state_e      state_q;
  logic [MAG_W-1:0] peak_acc;
  logic [SUM_W-1:0] sum_acc;
  logic [CW:0]      over_acc;

  logic [MAG_W-1:0] peak_nxt;
  logic [SUM_W-1:0] sum_nxt;
  logic [CW:0]      over_nxt;

  logic [MAG_W-1:0] peak_q;
  logic [MAG_W-1:0] avg_q;
  logic [CW:0]      over_q;
  logic             vld_q;

  assign mag         = bus.i_data[MAG_W-1:0];
  assign data_unused = ^bus.i_data[DATA_W-1:MAG_W];
  assign accept      = bus.i_valid & ~bus.i_clear;

  dsp_window_counter #(
    .WINDOW (WINDOW)
  ) u_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .inc   (accept),
    .clr   (bus.i_clear),
    .cnt   (cnt_unused),
    .last  (last)
  );

  // First sample of a window overwrites the stale peak.
  always_comb begin
    peak_nxt = peak_acc;
    if (state_q == IDLE || mag > peak_acc) begin
      peak_nxt = mag;
    end
    sum_nxt  = sum_acc + SUM_W'(mag);
    over_nxt = over_acc;
    if (mag > bus.i_thresh) begin
      over_nxt = over_acc + (CW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      peak_acc <= '0;
      sum_acc  <= '0;
      over_acc <= '0;
      peak_q   <= '0;
      avg_q    <= '0;
      over_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (bus.i_clear) begin
        state_q  <= IDLE;
        peak_acc <= '0;
        sum_acc  <= '0;
        over_acc <= '0;
      end else if (bus.i_valid) begin
        if (last) begin
          peak_q   <= peak_nxt;
          avg_q    <= sum_nxt[SUM_W-1:CW];
          over_q   <= over_nxt;
          vld_q    <= 1'b1;
          state_q  <= IDLE;
          peak_acc <= '0;
          sum_acc  <= '0;
          over_acc <= '0;
        end else begin
          state_q  <= ACCUM;
          peak_acc <= peak_nxt;
          sum_acc  <= sum_nxt;
          over_acc <= over_nxt;
        end
      end
    end
  end

  assign bus.o_peak  = peak_q;
  assign bus.o_avg   = avg_q;
  assign bus.o_over  = over_q;
  assign bus.o_valid = vld_q;

endmodule

// File: tb/tb_dsp_peak_detector.sv
// Scoreboard bench for dsp_peak_detector at WINDOW=4.
module tb_dsp_peak_detector;

  import dsp_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic [11:0] peak;
    logic [11:0] avg;
    logic [2:0]  over;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dsp_peak_detector_if #(
    .DATA_W (14),
    .MAG_W  (12),
    .WINDOW (W)
  ) bus ();

  dsp_peak_detector #(
    .DATA_W (14),
    .MAG_W  (12),
    .WINDOW (W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  res_t sb[$];
  int   strobe_cyc[$];

  int   m_cnt  = 0;
  int   m_peak = 0;
  int   m_sum  = 0;
  int   m_over = 0;
  int   h_peak = 0;
  int   h_avg  = 0;
  int   h_over = 0;
  bit   pend   = 1'b0;
  bit   pend_d = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_cnt  = 0;
    m_peak = 0;
    m_sum  = 0;
    m_over = 0;
  endtask

  task automatic drv(input logic [13:0] d,
                     input logic [11:0] th,
                     input bit clr);
    int   mag;
    res_t r;
    @(negedge clk);
    bus.i_data   = d;
    bus.i_valid  = 1'b1;
    bus.i_thresh = th;
    bus.i_clear  = clr;
    if (clr) begin
      m_clear();
    end else begin
      mag = int'(d[11:0]);
      if (m_cnt == 0 || mag > m_peak) m_peak = mag;
      m_sum += mag;
      if (mag > int'(th)) m_over++;
      m_cnt++;
      if (m_cnt == W) begin
        r.peak = 12'(m_peak);
        r.avg  = 12'(m_sum / W);
        r.over = 3'(m_over);
        sb.push_back(r);
        h_peak = m_peak;
        h_avg  = m_sum / W;
        h_over = m_over;
        pend   = 1'b1;
        m_clear();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_clear = 1'b0;
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_peak"}, 32'(bus.o_peak), 32'(h_peak));
    chk({tag, "_avg"},  32'(bus.o_avg),  32'(h_avg));
    chk({tag, "_over"}, 32'(bus.o_over), 32'(h_over));
  endtask

  always @(posedge clk) begin
    res_t r;
    #1;
    cyc++;
    if (bus.o_valid || pend || pend_d) begin
      chk("strobe", 32'(bus.o_valid), 32'(pend));
    end
    pend_d = pend;
    pend   = 1'b0;
    if (bus.o_valid) begin
      strobe_cyc.push_back(cyc);
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("peak", 32'(bus.o_peak), 32'(r.peak));
        chk("avg",  32'(bus.o_avg),  32'(r.avg));
        chk("over", 32'(bus.o_over), 32'(r.over));
      end
    end
  end

  initial begin
    logic [13:0] s [4];
    int n0;
    s[0] = 14'd10;
    s[1] = 14'd300;
    s[2] = 14'd2048;
    s[3] = 14'd5;

    bus.i_data   = '0;
    bus.i_valid  = 1'b0;
    bus.i_thresh = '0;
    bus.i_clear  = 1'b0;
    #2;
    chk_hold("rst0");
    chk("rst0_vld", 32'(bus.o_valid), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // basic window
    for (int i = 0; i < 4; i++) drv(s[i], 12'd100, 1'b0);
    idle(2);
    chk_hold("basic");
    chk("basic_avg590", 32'(bus.o_avg), 32'd590);

    // gapped window, 0..3 idle cycles between samples
    for (int i = 0; i < 4; i++) begin
      drv(s[i], 12'd100, 1'b0);
      idle(i);
    end
    idle(2);
    chk_hold("gap");

    // equality at threshold and ignored upper bits
    drv(14'd300,    12'd300, 1'b0);
    drv(14'h3005,   12'd300, 1'b0);
    drv(14'd301,    12'd300, 1'b0);
    drv(14'd299,    12'd300, 1'b0);
    idle(2);
    chk_hold("thr");

    // clear with the 3rd sample
    drv(14'd7, 12'd0, 1'b0);
    drv(14'd8, 12'd0, 1'b0);
    drv(14'd9, 12'd0, 1'b1);
    idle(2);
    chk_hold("clr3");
    for (int i = 1; i <= 4; i++) drv(14'(i), 12'd4, 1'b0);
    idle(2);
    chk_hold("clr_win");

    // clear on what would be the closing sample
    drv(14'd50, 12'd0, 1'b0);
    drv(14'd60, 12'd0, 1'b0);
    drv(14'd70, 12'd0, 1'b0);
    drv(14'd80, 12'd0, 1'b1);
    idle(3);
    chk_hold("clr4");

    // back-to-back, two windows
    n0 = strobe_cyc.size();
    for (int i = 0; i < 8; i++) begin
      drv(14'($urandom_range(0, 2048)),
          12'($urandom_range(0, 2048)), 1'b0);
    end
    idle(2);
    chk("b2b_strobes", 32'(strobe_cyc.size() - n0), 32'd2);
    if (strobe_cyc.size() >= n0 + 2) begin
      chk("b2b_gap",
          32'(strobe_cyc[n0+1] - strobe_cyc[n0]), 32'd4);
    end
    chk_hold("b2b");

    // async reset after sample 2 of a window
    drv(14'd1000, 12'd0, 1'b0);
    drv(14'd1500, 12'd0, 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #2;
    rst = 1'b1;
    m_clear();
    h_peak = 0;
    h_avg  = 0;
    h_over = 0;
    #1;
    chk_hold("arst");
    chk("arst_vld", 32'(bus.o_valid), 32'd0);
    idle(2);
    rst = 1'b0;
    drv(14'd50, 12'd60, 1'b0);
    drv(14'd60, 12'd60, 1'b0);
    drv(14'd70, 12'd60, 1'b0);
    drv(14'd80, 12'd60, 1'b0);
    idle(2);
    chk_hold("post_rst");
    chk("post_rst_avg65", 32'(bus.o_avg), 32'd65);

    idle(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
